// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C temperature-sensor target.
// No logic; latency and backpressure: n/a.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_BYTE,
        WR_ACK,
        TX_BYTE,
        TX_ACKCHK,
        WAIT_STOP
    } state_e;

    localparam logic        SDA_ACK     = 1'b0;
    localparam logic        SDA_NACK    = 1'b1;
    localparam logic        RW_WRITE    = 1'b0;
    localparam logic        RW_READ     = 1'b1;
    localparam logic [2:0]  BIT_LAST    = 3'd7;
    localparam logic [15:0] UNMAPPED_RD = 16'hFFFF;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and flags SCL edges plus START/STOP bus conditions.
// Latency: 3 clk from pad to event pulse; no backpressure (pulses are single-cycle).
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [0],[1] form the synchronizer, [2] holds the previous synchronized value
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    always_comb begin
        scl_d = {scl_q[1:0], scl_in};
        sda_d = {sda_q[1:0], sda_in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
    assign sda_s     =  sda_q[1];

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating a P3T1035/P3T2030: pointer, 16-bit config and temperature registers.
// Latency: responds ~3 clk after each SCL edge; no clock stretching, SDA open-drain via sda_oe.
module i2c_temp_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'b1111111,
    parameter logic [7:0]  TEMP_PTR    = 8'hFF,
    parameter logic [7:0]  CONF_PTR    = 8'h01,
    parameter logic [15:0] CONF_RESET  = 16'h60A0,
    parameter int          DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic [DATA_WIDTH-1:0] temp_value,
    output logic [DATA_WIDTH-1:0] config_q,
    output logic [7:0]            ptr_q,
    output logic                  busy,
    output logic                  rd_done
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_e          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            rw_q, rw_d;
    logic [15:0]     tx_q, tx_d;
    logic            byte_sel_q, byte_sel_d;
    logic [1:0]      wr_cnt_q, wr_cnt_d;
    logic [7:0]      stage_q, stage_d;
    logic [15:0]     config_d;
    logic [7:0]      ptr_d;
    logic            busy_q, busy_d;
    logic            sda_oe_q, sda_oe_d;
    logic            rd_done_q, rd_done_d;
    logic [3:0]      tx_idx;

    // byte_sel 0 walks bits 15..8, byte_sel 1 walks bits 7..0
    assign tx_idx = {~byte_sel_q, ~bit_cnt_q};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        tx_d       = tx_q;
        byte_sel_d = byte_sel_q;
        wr_cnt_d   = wr_cnt_q;
        stage_d    = stage_q;
        config_d   = config_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        rd_done_d  = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            if (state_q == ADDR) begin
                                if (shift_d[7:1] == TARGET_ADDR) begin
                                    state_d = ADDR_ACK;
                                    rw_d    = shift_d[0];
                                end else begin
                                    state_d = WAIT_STOP;
                                end
                            end else if (state_q == PTR) begin
                                state_d = PTR_ACK;
                            end else begin
                                state_d = WR_ACK;
                            end
                        end
                    end
                end

                // First falling edge pulls SDA for the ACK, second releases it
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (state_q == PTR_ACK) begin
                                ptr_d    = shift_q;
                                wr_cnt_d = 2'd0;
                            end else if (state_q == WR_ACK) begin
                                if (ptr_q == CONF_PTR) begin
                                    if (wr_cnt_q == 2'd0) begin
                                        stage_d = shift_q;
                                    end else if (wr_cnt_q == 2'd1) begin
                                        config_d = {stage_q, shift_q};
                                    end
                                end
                                if (wr_cnt_q != 2'd2) begin
                                    wr_cnt_d = wr_cnt_q + 2'd1;
                                end
                            end
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q != ADDR_ACK) begin
                                state_d = WR_BYTE;
                            end else if (rw_q == RW_WRITE) begin
                                state_d = PTR;
                            end else begin
                                if (ptr_q == TEMP_PTR) begin
                                    tx_d = temp_value;
                                end else if (ptr_q == CONF_PTR) begin
                                    tx_d = config_q;
                                end else begin
                                    tx_d = UNMAPPED_RD;
                                end
                                byte_sel_d = 1'b0;
                                sda_oe_d   = ~tx_d[15];
                                state_d    = TX_BYTE;
                            end
                        end
                    end
                end

                TX_BYTE: begin
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[tx_idx];
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = TX_ACKCHK;
                        end
                    end
                end

                TX_ACKCHK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_s == SDA_ACK) begin
                            byte_sel_d = ~byte_sel_q;
                            state_d    = TX_BYTE;
                        end else if (sda_s == SDA_NACK) begin
                            rd_done_d = (rw_q == RW_READ);
                            state_d   = WAIT_STOP;
                        end
                    end
                end

                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rw_q       <= 1'b0;
            tx_q       <= 16'h0000;
            byte_sel_q <= 1'b0;
            wr_cnt_q   <= 2'd0;
            stage_q    <= 8'h00;
            config_q   <= CONF_RESET;
            ptr_q      <= 8'h00;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rw_q       <= rw_d;
            tx_q       <= tx_d;
            byte_sel_q <= byte_sel_d;
            wr_cnt_q   <= wr_cnt_d;
            stage_q    <= stage_d;
            config_q   <= config_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            rd_done_q  <= rd_done_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign rd_done = rd_done_q;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bus-level bench: bit-banged I2C controller against a register-map reference model.
module tb_i2c_temp_target;

    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] temp_value;
    logic [15:0] config_q;
    logic [7:0]  ptr_q;
    logic        busy;
    logic        rd_done;
    logic        toggle_en;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;

    logic [15:0] m_conf;
    logic [7:0]  m_ptr;
    logic [7:0]  wbuf [8];

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    i2c_temp_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .temp_value (temp_value),
        .config_q   (config_q),
        .ptr_q      (ptr_q),
        .busy       (busy),
        .rd_done    (rd_done)
    );

    always @(posedge clk) begin
        if (rd_done) rd_cnt++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (toggle_en) temp_value = (temp_value == 16'h1111) ? 16'h2222 : 16'h1111;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_word();
        if (m_ptr == 8'hFF) return temp_value;
        if (m_ptr == 8'h01) return m_conf;
        return 16'hFFFF;
    endfunction

    task automatic half_wait();
        repeat (HP) @(posedge clk);
        #1;
    endtask

    task automatic hold();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        half_wait();
        scl_m = 1'b1;
        half_wait();
        scl_m = 1'b0;
        hold();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        half_wait();
        scl_m = 1'b1;
        half_wait();
        b = sda_line;
        scl_m = 1'b0;
        hold();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        half_wait();
        scl_m = 1'b1;
        half_wait();
        sda_m = 1'b0;
        half_wait();
        scl_m = 1'b0;
        hold();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        half_wait();
        scl_m = 1'b1;
        half_wait();
        sda_m = 1'b1;
        half_wait();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // Write transaction: wbuf[0] is the pointer, the rest are data bytes
    task automatic wr_txn(input logic [6:0] a, input int n, input string tag);
        logic ack;
        logic match;
        match = (a == 7'h7F);
        i2c_start();
        send_byte({a, 1'b0}, ack);
        check({tag, "_addr_ack"}, 32'(ack), match ? 32'd0 : 32'd1);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                send_byte(wbuf[i], ack);
                check({tag, "_data_ack"}, 32'(ack), 32'd0);
            end
        end
        i2c_stop();
        if (match && n >= 1) begin
            m_ptr = wbuf[0];
            if (m_ptr == 8'h01 && n >= 3) m_conf = {wbuf[1], wbuf[2]};
        end
        check({tag, "_ptr"}, 32'(ptr_q), 32'(m_ptr));
        check({tag, "_conf"}, 32'(config_q), 32'(m_conf));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic rd_txn(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
        logic        ack;
        logic [7:0]  d;
        logic [15:0] word;
        int          rd0;
        rd0 = rd_cnt;
        i2c_start();
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        if (set_ptr) begin
            send_byte({7'h7F, 1'b0}, ack);
            check({tag, "_waddr_ack"}, 32'(ack), 32'd0);
            send_byte(p, ack);
            check({tag, "_ptr_ack"}, 32'(ack), 32'd0);
            m_ptr = p;
            i2c_start();
        end
        send_byte({7'h7F, 1'b1}, ack);
        check({tag, "_raddr_ack"}, 32'(ack), 32'd0);
        word = m_word();
        for (int i = 0; i < n; i++) begin
            recv_byte(d, i == n - 1);
            check({tag, "_byte"}, 32'(d), (i % 2 == 0) ? 32'(word[15:8]) : 32'(word[7:0]));
        end
        i2c_stop();
        check({tag, "_rd_done"}, 32'(rd_cnt - rd0), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic        ack;
        logic        b;
        logic [7:0]  rb [4];
        logic [15:0] v;
        logic [7:0]  p;
        int          n;

        rst_n      = 1'b0;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        temp_value = 16'h0000;
        toggle_en  = 1'b0;
        m_conf     = 16'h60A0;
        m_ptr      = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_conf", 32'(config_q), 32'h60A0);
        check("rst_ptr", 32'(ptr_q), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Temperature read with pointer set + repeated START
        temp_value = 16'hA5C3;
        rd_txn(1'b1, 8'hFF, 2, "temp_read");

        // Address mismatch: target must stay silent
        begin
            int oe_cyc;
            oe_cyc = 0;
            fork
                begin
                    wbuf[0] = 8'h01;
                    wr_txn(7'h48, 1, "mismatch");
                end
                begin
                    repeat (400) begin
                        @(posedge clk);
                        #1;
                        if (sda_oe) oe_cyc++;
                    end
                end
            join
            check("mismatch_oe_cycles", 32'(oe_cyc), 32'd0);
        end

        // Config write then read-back
        wbuf[0] = 8'h01; wbuf[1] = 8'h12; wbuf[2] = 8'h34;
        wr_txn(7'h7F, 3, "conf_wr");
        rd_txn(1'b0, 8'h01, 2, "conf_rd");

        // Snapshot coherency with temp_value toggling every clk
        wbuf[0] = 8'hFF;
        wr_txn(7'h7F, 1, "ptr_temp");
        temp_value = 16'h1111;
        toggle_en  = 1'b1;
        i2c_start();
        send_byte({7'h7F, 1'b1}, ack);
        check("toggle_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) recv_byte(rb[i], i == 3);
        i2c_stop();
        toggle_en = 1'b0;
        check("toggle_word_valid", 32'(rb[0] == 8'h11 || rb[0] == 8'h22), 32'd1);
        check("toggle_lsb", 32'(rb[1]), 32'(rb[0]));
        check("toggle_wrap_msb", 32'(rb[2]), 32'(rb[0]));
        check("toggle_wrap_lsb", 32'(rb[3]), 32'(rb[0]));

        // STOP in the middle of the config LSB discards the write
        i2c_start();
        send_byte({7'h7F, 1'b0}, ack);
        send_byte(8'h01, ack);
        send_byte(8'hAB, ack);
        check("partial_msb_ack", 32'(ack), 32'd0);
        m_ptr = 8'h01;
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        i2c_stop();
        check("partial_conf", 32'(config_q), 32'(m_conf));
        check("partial_busy", 32'(busy), 32'd0);
        check("partial_sda_oe", 32'(sda_oe), 32'd0);

        // Randomized register traffic
        for (int it = 0; it < 3; it++) begin
            temp_value = 16'($urandom);
            v = 16'($urandom);
            n = 3 + $urandom_range(0, 2);
            wbuf[0] = 8'h01; wbuf[1] = v[15:8]; wbuf[2] = v[7:0];
            wbuf[3] = 8'($urandom); wbuf[4] = 8'($urandom);
            wr_txn(7'h7F, n, "rnd_conf_wr");
            rd_txn(1'b1, 8'h01, $urandom_range(2, 5), "rnd_conf_rd");
            rd_txn(1'b1, 8'hFF, $urandom_range(1, 4), "rnd_temp_rd");
            p = 8'($urandom_range(2, 254));
            wbuf[0] = p; wbuf[1] = 8'($urandom); wbuf[2] = 8'($urandom);
            wr_txn(7'h7F, 3, "rnd_unmapped_wr");
            rd_txn(1'b0, p, 2, "rnd_unmapped_rd");
        end

        // Reset while the target is driving a data bit low
        temp_value = 16'h0000;
        wbuf[0] = 8'hFF;
        wr_txn(7'h7F, 1, "rst_ptr_set");
        i2c_start();
        send_byte({7'h7F, 1'b1}, ack);
        recv_bit(b);
        recv_bit(b);
        begin
            int k;
            k = 0;
            while (k < 40 && !sda_oe) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check("midtx_driving", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_conf = 16'h60A0;
        m_ptr  = 8'h00;
        check("midtx_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("midtx_rst_conf", 32'(config_q), 32'(m_conf));
        check("midtx_rst_ptr", 32'(ptr_q), 32'(m_ptr));
        check("midtx_rst_busy", 32'(busy), 32'd0);
        i2c_stop();
        rd_txn(1'b0, 8'h00, 2, "post_rst_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_temp_target.md
Name: i2c_temp_target

Overview:
Synthesizable I2C target (responder) that emulates the P3T1035/P3T2030 temperature sensor's bus behaviour. It is the far end of the TCU's I2C controller.
- Handles address match, pointer-byte write, repeated START, and 16-bit big-endian register reads and writes.
- Used for FPGA loop-back of TCU_wrapper and as a reusable sensor model in system benches.
- Drives SDA open-drain through an output-enable only; never drives SCL (no clock stretching).

Parameters:
TARGET_ADDR, 7'b1111111, 7-bit I2C address this target responds to
TEMP_PTR, 8'hFF, pointer value selecting the read-only temperature register
CONF_PTR, 8'h01, pointer value selecting the read/write config register
CONF_RESET, 16'h60A0, reset value of the config register
DATA_WIDTH, 16, register width; fixed at 2 bytes

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
scl_in  input  1  SCL line as seen at the pad (asynchronous)
sda_in  input  1  SDA line as seen at the pad (asynchronous)
sda_oe  output  1  1 = pull SDA low; 0 = release (pad ties output data to 0)
temp_value  input  16  live temperature word served on TEMP_PTR reads
config_q  output  16  config register contents
ptr_q  output  8  current pointer register
busy  output  1  high from START until STOP or return to IDLE
rd_done  output  1  one-cycle pulse when a read ends with a controller NACK

Behaviour:
- Input conditioning: scl_in and sda_in pass through 2-flop synchronizers, plus a third flop for edge detection.
- Bus condition detection (on synchronized signals):
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Bit sample = SCL rising edge; drive update = SCL falling edge.
- Reset values: sda_oe=0, config_q=CONF_RESET, ptr_q=8'h00, busy=0, rd_done=0, state=IDLE. The shifter, bit counter and snapshot all clear to 0.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, TX_BYTE, TX_ACKCHK, WAIT_STOP.
- START in any state (including repeated START) → ADDR with bit counter 0, sda_oe=0, busy=1.
- STOP in any state → IDLE with sda_oe=0, busy=0. Any partial write byte is discarded.
- ADDR: shift 8 bits MSB first.
  - Match on bits [7:1]==TARGET_ADDR → ADDR_ACK; otherwise → WAIT_STOP (no ACK, sda_oe stays 0).
  - Bit 0 = 0 means write, 1 means read.
- ACK timing: sda_oe=1 from the SCL falling edge after the 8th bit until the next SCL falling edge.
- Address phase, write direction: ADDR_ACK → PTR.
- Address phase, read direction:
  - At the ADDR_ACK falling edge, snapshot the selected register into a 16-bit tx buffer: temp_value if ptr_q==TEMP_PTR, config_q if ptr_q==CONF_PTR, else 16'hFFFF.
  - Then → TX_BYTE, MSB byte first.
- PTR: 8 bits → ptr_q updated at the ACK falling edge → PTR_ACK → WR_BYTE.
- WR_BYTE/WR_ACK: every received byte is ACKed.
  - Write-only when ptr_q==CONF_PTR: first byte → config[15:8] staging, second byte → config[7:0].
  - config_q commits atomically at the second ACK falling edge.
  - Bytes beyond the 2nd are ACKed and ignored.
  - Writes to other pointers are ACKed and discarded.
- TX_BYTE:
  - Present each bit on the SCL falling edge: sda_oe = ~bit. The first bit is presented at the ACK-release falling edge.
  - After 8 bits release SDA → TX_ACKCHK, then sample SDA at SCL rising.
  - SDA=0 (ACK) → next byte. After LSB, wrap to MSB of the same snapshot; no re-snapshot within a transaction.
  - SDA=1 (NACK) → rd_done pulse, → WAIT_STOP.
- Snapshot coherency: temp_value changes after the snapshot do not affect the bytes in flight.
- WAIT_STOP: sda_oe=0; leave only on START or STOP.
- START/STOP detection has priority over a coincident bit edge in the same cycle.
- Minimum legal SCL half-period is 4 clk cycles; shorter is unsupported.

Decomposition:
- Package i2c_target_pkg: state enum, ACK/NACK and RW-bit constants, 3'd7 bit-count terminal value, 16'hFFFF unmapped-read constant.
- Sub-module i2c_line_sync: synchronizers for both lines plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
1. Write addr 7'b1111111+W, pointer 8'hFF; repeated START; addr+R; temp_value=16'hA5C3; controller ACKs MSB, NACKs LSB → bytes 8'hA5, 8'hC3 on SDA, three target ACKs, rd_done pulses once, busy low after STOP.
2. Address 7'h48 (mismatch) → no ACK (SDA high at 9th SCL), sda_oe never asserted, ptr_q unchanged.
3. Write CONF_PTR then 8'h12, 8'h34, STOP; read back → config_q=16'h1234, read returns 8'h12, 8'h34.
4. temp_value toggles 16'h1111↔16'h2222 every clk during a read → received word equals the value at the ADDR_ACK snapshot, never mixed bytes.
5. STOP after 4 bits of the config LSB → config_q unchanged, state IDLE, sda_oe=0.
6. rst_n=0 for one cycle mid-TX_BYTE while driving low → next cycle sda_oe=0, config_q=16'h60A0, ptr_q=0, busy=0.
